// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the I/O register-file host port: master 0 has fixed priority,
// master 1 has a bounded wait, and a locked owner keeps the bus for read-modify-write.
module io_bus_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m0_gnt,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rvalid,
    output logic                  m1_gnt,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rvalid,
    output logic                  s_cs,
    output logic                  s_we,
    output logic                  s_oe,
    output logic [ADDR_WIDTH-1:0] s_addr,
    inout  wire  [DATA_WIDTH-1:0] s_data
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [WAIT_W-1:0]       wait1_r;
    logic                    drive_s;
    logic [DATA_WIDTH-1:0]   wdata_s;

    // Arbitration: a locked owner keeps the bus; an unlocked owner must sit out one cycle.
    always_comb begin
        next_state_s = IDLE;
        if (state_r == OWN0 && m0_req && m0_lock) begin
            next_state_s = OWN0;
        end else if (state_r == OWN1 && m1_req && m1_lock) begin
            next_state_s = OWN1;
        end else if (m1_req && (!m0_req || wait1_r == WAIT_SAT) && state_r != OWN1) begin
            next_state_s = OWN1;
        end else if (m0_req && state_r != OWN0) begin
            next_state_s = OWN0;
        end else if (m1_req && state_r != OWN1) begin
            next_state_s = OWN1;
        end else begin
            next_state_s = IDLE;
        end
    end

    // Ownership state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Count cycles master 1 loses arbitration, saturating at the starvation limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait1_r <= '0;
        end else if (!m1_req || next_state_s == OWN1) begin
            wait1_r <= '0;
        end else if (wait1_r != WAIT_SAT) begin
            wait1_r <= wait1_r + WAIT_W'(1);
        end else begin
            wait1_r <= wait1_r;
        end
    end

    // Host-port strobes follow the current owner directly.
    always_comb begin
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        s_cs    = 1'b0;
        s_we    = 1'b0;
        s_oe    = 1'b0;
        s_addr  = '0;
        drive_s = 1'b0;
        wdata_s = '0;
        case (state_r)
            OWN0: begin
                m0_gnt  = 1'b1;
                s_cs    = 1'b1;
                s_we    = m0_we;
                s_oe    = !m0_we;
                s_addr  = m0_addr;
                drive_s = m0_we;
                wdata_s = m0_wdata;
            end
            OWN1: begin
                m1_gnt  = 1'b1;
                s_cs    = 1'b1;
                s_we    = m1_we;
                s_oe    = !m1_we;
                s_addr  = m1_addr;
                drive_s = m1_we;
                wdata_s = m1_wdata;
            end
            IDLE: begin
                drive_s = 1'b0;
            end
            default: begin
                drive_s = 1'b0;
            end
        endcase
    end

    assign s_data = drive_s ? wdata_s : {DATA_WIDTH{1'bz}};

    // Capture read data at the end of a read grant; rdata holds until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= (state_r == OWN0) && !m0_we;
            m1_rvalid <= (state_r == OWN1) && !m1_we;
            if (state_r == OWN0 && !m0_we) begin
                m0_rdata <= s_data;
            end else begin
                m0_rdata <= m0_rdata;
            end
            if (state_r == OWN1 && !m1_we) begin
                m1_rdata <= s_data;
            end else begin
                m1_rdata <= m1_rdata;
            end
        end
    end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master arbiter that shares the single host port of the I/O register file (cs/we/oe/address/data) between the CPU (master 0) and a secondary requester such as a DMA or debug engine (master 1). Master 0 has fixed priority, master 1 gets a bounded-starvation guarantee, and either master can lock the bus for read-modify-write sequences. It sits between the masters and the I/O register file and is the only driver of that file's cs/we/oe/address/data lines.

## Interface
- DATA_WIDTH, 8, width of data buses
- ADDR_WIDTH, 6, I/O register address width
- MAX_WAIT, 4, number of consecutive lost arbitration cycles after which master 1 beats master 0 (≥1)
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  reset, synchronous, active-high
- m0_req, m1_req  input  1  transfer request (level), held until granted
- m0_lock, m1_lock  input  1  keep ownership for the next cycle
- m0_we, m1_we  input  1  1 = write, 0 = read
- m0_addr, m1_addr  input  ADDR_WIDTH  register address
- m0_wdata, m1_wdata  input  DATA_WIDTH  write data
- m0_gnt, m1_gnt  output  1  the transfer is executing in this cycle
- m0_rdata, m1_rdata  output  DATA_WIDTH  registered read data
- m0_rvalid, m1_rvalid  output  1  one-cycle pulse, rdata updated
- s_cs, s_we, s_oe  output  1  register-file strobes
- s_addr  output  ADDR_WIDTH  register-file address
- s_data  inout  DATA_WIDTH  register-file data; driven only during a granted write, else Z

## Operation
- State register: IDLE, OWN0, OWN1. Reset → IDLE.
- Next-state evaluation at each posedge, in priority order:
  - Owner N with mN_req=1 and mN_lock=1 → stay OWNN.
  - m1_req=1 and (m0_req=0 or wait1==MAX_WAIT), and master 1 is not the current unlocked owner → OWN1.
  - m0_req=1 and master 0 is not the current unlocked owner → OWN0.
  - m1_req=1 and master 1 is not the current unlocked owner → OWN1.
  - Otherwise → IDLE.
- An unlocked owner is never re-granted in the next cycle. Each unlocked transfer is followed by at least one cycle in which the other master or IDLE holds the bus.
- wait1 counter (width clog2(MAX_WAIT+1)):
  - Increments, saturating at MAX_WAIT, at each posedge where m1_req=1 and next state ≠ OWN1.
  - Clears when master 1 is granted or m1_req=0.
- Outputs in OWNN are combinational from the state:
  - mN_gnt=1, s_cs=1, s_we=mN_we, s_oe=!mN_we, s_addr=mN_addr.
  - s_data=mN_wdata when mN_we=1, otherwise Z.
- Outputs in IDLE: all gnt=0, s_cs=s_we=s_oe=0, s_addr=0, s_data=Z.
- Read return: at the posedge ending an OWNN cycle with mN_we=0, mN_rdata ← s_data and mN_rvalid=1 for one cycle.
- rdata holds its value until the next read by the same master.
- Masters hold req/we/addr/wdata stable from assertion through the grant cycle. A master drops req or presents a new transfer after sampling gnt=1.
- Lock with req=0 releases ownership; lock without ownership has no effect.

## Timing
- Reset values: state IDLE, wait1=0, gnt=0, rvalid=0, rdata=0, s_cs/s_we/s_oe=0, s_addr=0, s_data=Z.
- Minimum latency: req rises in cycle k → gnt in cycle k+1 when uncontested.
- One transfer per grant cycle.
- The register file latches the write or the read address on the negedge within the grant cycle. Read data is valid before the following posedge and is captured there.
- Unlocked throughput: one transfer per 2 cycles per master. Two alternating masters can use every cycle.
- Locked throughput: back-to-back transfers every cycle.
- Simultaneous requests from IDLE with wait1<MAX_WAIT: master 0 wins.
- Starvation bound: with m0 streaming requests, m1 is granted no later than MAX_WAIT+2 cycles after req, unless m0 holds lock.
- m0 lock may starve m1 indefinitely. Software bounds lock sequences.
- Reset asserted mid-grant: state, gnt and strobes return to reset values after that posedge. An in-flight read produces no rvalid.

## Test plan
- m0 single write, addr 0x1B, data 0xA5 → m0_gnt, s_cs=1, s_we=1 and s_data=0xA5 in cycle k+1; register 0x1B reads back 0xA5.
- m1 read of a register holding 0x3C → m1_gnt in cycle k+1, then m1_rvalid pulse with m1_rdata=0x3C at cycle k+2.
- m0 and m1 request in the same IDLE cycle → m0 granted first, m1 granted in the following cycle.
- m0 continuously re-requests, m1 requesting, MAX_WAIT=4 → m1 granted within 6 cycles and wait1 clears to 0.
- m0 holds lock for a 3-cycle read-modify-write while m1 requests → OWN0 for 3 consecutive cycles, m1 granted immediately after m0_lock drops.
- reset pulsed during an OWN1 read → next cycle IDLE, all gnt=0, no m1_rvalid, wait1=0.
